// File: rtl/lsu_io.sv
// lsu_io: memory-mapped load/store unit with data RAM and board I/O.
// Optional button debouncer enabled by defining LSU_BTN_DEBOUNCE_EN.
module lsu_io #(
    parameter int DMEM_WORDS      = 2048,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_lsu_funct3,
    output logic [31:0] o_ld_data,
    output logic        o_misaligned,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn
);
    localparam int AW = $clog2(DMEM_WORDS);

    localparam logic [31:0] A_LEDR  = 32'h1000_0000;
    localparam logic [31:0] A_LEDG  = 32'h1000_1000;
    localparam logic [31:0] A_HEX03 = 32'h1000_2000;
    localparam logic [31:0] A_HEX47 = 32'h1000_3000;
    localparam logic [31:0] A_LCD   = 32'h1000_4000;
    localparam logic [31:0] A_SW    = 32'h1001_0000;
    localparam logic [31:0] A_BTN   = 32'h1001_1000;

    logic [31:0]      mem [DMEM_WORDS];
    logic [AW-1:0]    idx;
    logic             is_b, is_h, is_w, uns;
    logic             sel_mem, sel_ledr, sel_ledg, sel_hex03;
    logic             sel_hex47, sel_lcd, sel_sw, sel_btn;
    logic             st_ok;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      rword;
    logic [31:0]      rshift;
    logic [31:0]      ledr_q, ledg_q, lcd_q;
    logic [7:0][6:0]  hex_q;
    logic [31:0]      sw_s1, sw_s2;
    logic [3:0]       btn_s1, btn_s2, btn_db;

    assign idx = i_lsu_addr[AW+1:2];

    // Access size and address window decode.
    always_comb begin
        is_b      = (i_lsu_funct3 == 3'b000) || (i_lsu_funct3 == 3'b100);
        is_h      = (i_lsu_funct3 == 3'b001) || (i_lsu_funct3 == 3'b101);
        is_w      = !is_b && !is_h;
        uns       = i_lsu_funct3[2];
        sel_mem   = (i_lsu_addr[31:AW+2] == '0);
        sel_ledr  = (i_lsu_addr[31:2] == A_LEDR[31:2]);
        sel_ledg  = (i_lsu_addr[31:2] == A_LEDG[31:2]);
        sel_hex03 = (i_lsu_addr[31:2] == A_HEX03[31:2]);
        sel_hex47 = (i_lsu_addr[31:2] == A_HEX47[31:2]);
        sel_lcd   = (i_lsu_addr[31:2] == A_LCD[31:2]);
        sel_sw    = (i_lsu_addr[31:2] == A_SW[31:2]);
        sel_btn   = (i_lsu_addr[31:2] == A_BTN[31:2]);
        o_misaligned = (is_h && i_lsu_addr[0])
                    || (is_w && (i_lsu_addr[1:0] != 2'b00));
        st_ok     = i_lsu_wren && !i_rst && !o_misaligned;
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        be    = 4'b1111;
        wdata = i_st_data;
        if (is_b) begin
            be    = 4'b0001 << i_lsu_addr[1:0];
            wdata = {4{i_st_data[7:0]}};
        end else if (is_h) begin
            be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{i_st_data[15:0]}};
        end
    end

    // Data RAM byte-lane writes; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (st_ok && sel_mem) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Board output registers, written only by stores.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= '0;
            hex_q  <= {8{7'h7F}};
        end else if (st_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    if (sel_ledr)  ledr_q[8*i +: 8] <= wdata[8*i +: 8];
                    if (sel_ledg)  ledg_q[8*i +: 8] <= wdata[8*i +: 8];
                    if (sel_lcd)   lcd_q[8*i +: 8]  <= wdata[8*i +: 8];
                    if (sel_hex03) hex_q[i]         <= wdata[8*i +: 7];
                    if (sel_hex47) hex_q[i+4]       <= wdata[8*i +: 7];
                end
            end
        end
    end

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            sw_s1  <= i_io_sw;
            sw_s2  <= sw_s1;
            btn_s1 <= i_io_btn;
            btn_s2 <= btn_s1;
        end
    end

`ifdef LSU_BTN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_q [4];

    // Per-button stability counter; output follows after a steady run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            btn_db <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] == btn_db[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_db[i] <= btn_s2[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end
`else
    logic unused_dbc;
    assign unused_dbc = DEBOUNCE_CYCLES[0];
    assign btn_db     = btn_s2;
`endif

    // Addressed-word read mux.
    always_comb begin
        rword = '0;
        unique case (1'b1)
            sel_mem:   rword = mem[idx];
            sel_ledr:  rword = ledr_q;
            sel_ledg:  rword = ledg_q;
            sel_hex03: rword = {1'b0, hex_q[3], 1'b0, hex_q[2],
                                1'b0, hex_q[1], 1'b0, hex_q[0]};
            sel_hex47: rword = {1'b0, hex_q[7], 1'b0, hex_q[6],
                                1'b0, hex_q[5], 1'b0, hex_q[4]};
            sel_lcd:   rword = lcd_q;
            sel_sw:    rword = sw_s2;
            sel_btn:   rword = {28'b0, btn_db};
            default:   rword = '0;
        endcase
    end

    // Lane select and extension; bad accesses load zero.
    always_comb begin
        rshift    = rword >> {i_lsu_addr[1:0], 3'b000};
        o_ld_data = rword;
        if (is_b)
            o_ld_data = {{24{!uns && rshift[7]}}, rshift[7:0]};
        else if (is_h)
            o_ld_data = {{16{!uns && rshift[15]}}, rshift[15:0]};
        if (o_misaligned)
            o_ld_data = '0;
    end

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    assign o_io_hex0 = hex_q[0];
    assign o_io_hex1 = hex_q[1];
    assign o_io_hex2 = hex_q[2];
    assign o_io_hex3 = hex_q[3];
    assign o_io_hex4 = hex_q[4];
    assign o_io_hex5 = hex_q[5];
    assign o_io_hex6 = hex_q[6];
    assign o_io_hex7 = hex_q[7];
endmodule

// File: tb/tb_lsu_io.sv
// tb_lsu_io: directed-vector bench for lsu_io.
// Debounce checks follow LSU_BTN_DEBOUNCE_EN, with DEBOUNCE_CYCLES=8.
module tb_lsu_io;
    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        wren;
    logic [2:0]  funct3;
    logic [31:0] ld_data;
    logic        misaligned;
    logic [31:0] ledr, ledg, lcd;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [31:0] sw;
    logic [3:0]  btn;

    int checks = 0;
    int errors = 0;

    lsu_io #(.DMEM_WORDS(2048), .DEBOUNCE_CYCLES(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_lsu_addr(addr), .i_st_data(st_data),
        .i_lsu_wren(wren), .i_lsu_funct3(funct3),
        .o_ld_data(ld_data), .o_misaligned(misaligned),
        .o_io_ledr(ledr), .o_io_ledg(ledg),
        .o_io_hex0(hex0), .o_io_hex1(hex1),
        .o_io_hex2(hex2), .o_io_hex3(hex3),
        .o_io_hex4(hex4), .o_io_hex5(hex5),
        .o_io_hex6(hex6), .o_io_hex7(hex7),
        .o_io_lcd(lcd), .i_io_sw(sw), .i_io_btn(btn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] d);
        addr = a; funct3 = f; st_data = d; wren = 1'b1;
        step();
        wren = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] f);
        addr = a; funct3 = f;
        #1;
    endtask

    initial begin
        rst = 1'b1; wren = 1'b0; addr = '0; st_data = '0;
        funct3 = 3'b010; sw = '0; btn = '0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_ledr", ledr, 32'h0);
        check("rst_ledg", ledg, 32'h0);
        check("rst_lcd", lcd, 32'h0);
        check("rst_hex0", {25'b0, hex0}, 32'h7F);
        check("rst_hex7", {25'b0, hex7}, 32'h7F);

        store(32'h100, 3'b010, 32'h8081_82F3);
        load(32'h100, 3'b000); check("lb", ld_data, 32'hFFFF_FFF3);
        load(32'h101, 3'b100); check("lbu", ld_data, 32'h0000_0082);
        load(32'h102, 3'b001); check("lh", ld_data, 32'hFFFF_8081);
        load(32'h102, 3'b101); check("lhu", ld_data, 32'h0000_8081);
        load(32'h100, 3'b010); check("lw", ld_data, 32'h8081_82F3);
        load(32'h100, 3'b111); check("lw_f7", ld_data, 32'h8081_82F3);

        store(32'h1000_2001, 3'b000, 32'h0000_003F);
        check("hex1", {25'b0, hex1}, 32'h3F);
        check("hex0", {25'b0, hex0}, 32'h7F);
        check("hex2", {25'b0, hex2}, 32'h7F);
        check("hex3", {25'b0, hex3}, 32'h7F);
        load(32'h1000_2000, 3'b010);
        check("hex_rd", ld_data, 32'h7F7F_3F7F);
        store(32'h1000_0002, 3'b001, 32'h0000_1234);
        check("ledr_sh", ledr, 32'h1234_0000);

        addr = 32'h102; funct3 = 3'b010;
        st_data = 32'hFFFF_FFFF; wren = 1'b1;
        #1;
        check("mis_st", {31'b0, misaligned}, 32'h1);
        step();
        wren = 1'b0;
        load(32'h103, 3'b001);
        check("mis_ld", {31'b0, misaligned}, 32'h1);
        check("mis_ld0", ld_data, 32'h0);
        load(32'h100, 3'b010);
        check("mis_mem", ld_data, 32'h8081_82F3);
        load(32'h2000_0000, 3'b010);
        check("unmap_ld", ld_data, 32'h0);
        check("unmap_mis", {31'b0, misaligned}, 32'h0);

        store(32'h10, 3'b010, 32'h1122_3344);
        addr = 32'h10; funct3 = 3'b010;
        st_data = 32'hDEAD_BEEF; wren = 1'b1;
        #1;
        check("rdw_old", ld_data, 32'h1122_3344);
        step();
        wren = 1'b0;
        #1;
        check("rdw_new", ld_data, 32'hDEAD_BEEF);

        rst = 1'b1;
        store(32'h1000_1000, 3'b010, 32'hFFFF_FFFF);
        rst = 1'b0;
        check("rst_st_ledg", ledg, 32'h0);
        check("rst_ledr2", ledr, 32'h0);

        load(32'h1001_0000, 3'b010);
        sw = 32'hA5A5_A5A5;
        #1;
        check("sw_n", ld_data, 32'h0);
        step();
        check("sw_n1", ld_data, 32'h0);
        step();
        check("sw_n2", ld_data, 32'hA5A5_A5A5);
        store(32'h1001_0000, 3'b010, 32'h0);
        load(32'h1001_0000, 3'b010);
        check("sw_ro", ld_data, 32'hA5A5_A5A5);

        load(32'h1001_1000, 3'b010);
`ifdef LSU_BTN_DEBOUNCE_EN
        btn = 4'b0001;
        for (int k = 1; k <= 5; k++) step();
        btn = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("btn_glitch", ld_data, 32'h0);
        end
        btn = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("btn_db_%0d", k), ld_data,
                  (k >= 10) ? 32'h1 : 32'h0);
        end
`else
        btn = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("btn_sync_%0d", k), ld_data,
                  (k >= 2) ? 32'h1 : 32'h0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
